line_encoder: RTL

LINE_ENCODER -- requirements
Module: line_encoder

---
 rtl/line_encoder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/line_encoder.sv
`timescale 1ns/1ps
// line_encoder: renders normalized light-grid instructions back into ASCII text lines.
// Optional LINE_ENCODER_EOF_EN: remember an end_of_file pulse and emit one 0x04 byte once idle.
module line_encoder #(
    parameter int INSTRUCTION_WIDTH   = 52,
    parameter int OUTBOUND_DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           instr_valid,
    output logic                           instr_ready,
    input  logic [INSTRUCTION_WIDTH-1:0]   instr_data,
    input  logic                           end_of_file,
    output logic                           outbound_valid,
    input  logic                           outbound_ready,
    output logic [OUTBOUND_DATA_WIDTH-1:0] outbound_data,
    output logic                           format_error
);
    typedef enum logic [2:0] {IDLE, CONVERT, PREFIX, NUM, SEP, NEWLINE, EOT} state_t;

    state_t      state, state_nxt;
    logic        live;
    logic [1:0]  op;
    logic [11:0] bin [4];
    logic [15:0] bcd [4];
    logic [3:0]  cnt, cnt_nxt;
    logic [1:0]  fld, fld_nxt;
    logic        eof_pend;
    logic        accept, fire;
    logic [7:0]  byte_c;
    logic [15:0] bcd_sel;
    logic [2:0]  ndig, pos;
    logic [3:0]  plen;
    logic [1:0]  unused_bits;

    assign unused_bits = instr_data[1:0];

    // One double-dabble iteration: add-3 correction on every BCD nibble, then shift in the next bit.
    function automatic logic [27:0] dd_step(input logic [15:0] b, input logic [11:0] v);
        logic [15:0] a;
        a = b;
        for (int i = 0; i < 4; i++)
            if (a[i*4 +: 4] >= 4'd5) a[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
        return {a[14:0], v, 1'b0};
    endfunction

    function automatic logic [7:0] prefix_char(input logic [1:0] o, input logic [3:0] i);
        logic [71:0] s;
        case (o)
            2'b00:   s = "turn off ";
            2'b01:   s = {"turn on ", 8'h00};
            default: s = {"toggle ", 16'h0000};
        endcase
        s = s << {i, 3'b000};
        return s[71:64];
    endfunction

    function automatic logic [7:0] through_char(input logic [3:0] i);
        logic [71:0] s;
        s = " through ";
        s = s << {i, 3'b000};
        return s[71:64];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            fld          <= 2'd0;
            live         <= 1'b0;
            format_error <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            fld          <= fld_nxt;
            live         <= 1'b1;
            format_error <= accept && (instr_data[51:50] == 2'b11);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op     <= instr_data[51:50];
            bin[0] <= instr_data[49:38];
            bin[1] <= instr_data[37:26];
            bin[2] <= instr_data[25:14];
            bin[3] <= instr_data[13:2];
            for (int i = 0; i < 4; i++) bcd[i] <= 16'd0;
        end else if (state == CONVERT) begin
            for (int i = 0; i < 4; i++) {bcd[i], bin[i]} <= dd_step(bcd[i], bin[i]);
        end
    end

`ifdef LINE_ENCODER_EOF_EN
    always_ff @(posedge clk) begin
        if (reset)
            eof_pend <= 1'b0;
        else if (end_of_file)
            eof_pend <= 1'b1;
        else if (state_nxt == EOT && state != EOT)
            eof_pend <= 1'b0;
    end
`else
    logic unused_eof;
    assign unused_eof = end_of_file;
    assign eof_pend   = 1'b0;
`endif

    assign instr_ready = (state == IDLE) && live;
    assign bcd_sel     = bcd[fld];
    assign ndig        = (bcd_sel[15:12] != 4'd0) ? 3'd4 :
                         (bcd_sel[11:8]  != 4'd0) ? 3'd3 :
                         (bcd_sel[7:4]   != 4'd0) ? 3'd2 : 3'd1;
    assign pos         = ndig - 3'd1 - cnt[2:0];
    assign plen        = (op == 2'b00) ? 4'd9 : (op == 2'b01) ? 4'd8 : 4'd7;

    always_comb begin
        outbound_valid = 1'b0;
        byte_c         = 8'h00;
        case (state)
            PREFIX:  begin outbound_valid = 1'b1; byte_c = prefix_char(op, cnt); end
            NUM:     begin outbound_valid = 1'b1; byte_c = 8'h30 + {4'd0, bcd_sel[{pos[1:0], 2'b00} +: 4]}; end
            SEP:     begin outbound_valid = 1'b1; byte_c = (fld == 2'd1) ? through_char(cnt) : 8'h2C; end
            NEWLINE: begin outbound_valid = 1'b1; byte_c = 8'h0A; end
            EOT:     begin outbound_valid = 1'b1; byte_c = 8'h04; end
            default: ;
        endcase
    end

    assign outbound_data = OUTBOUND_DATA_WIDTH'(byte_c);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fld_nxt   = fld;
        accept    = instr_valid && instr_ready;
        fire      = outbound_valid && outbound_ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (instr_data[51:50] != 2'b11) begin
                        state_nxt = CONVERT;
                        cnt_nxt   = 4'd0;
                    end
                end else if (eof_pend) begin
                    state_nxt = EOT;
                end
            end
            CONVERT: begin
                if (cnt == 4'd11) begin
                    state_nxt = PREFIX;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            PREFIX: if (fire) begin
                if (cnt == plen - 4'd1) begin
                    state_nxt = NUM;
                    cnt_nxt   = 4'd0;
                    fld_nxt   = 2'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            NUM: if (fire) begin
                if (cnt[2:0] == ndig - 3'd1) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = (fld == 2'd3) ? NEWLINE : SEP;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            SEP: if (fire) begin
                if (fld != 2'd1 || cnt == 4'd8) begin
                    state_nxt = NUM;
                    cnt_nxt   = 4'd0;
                    fld_nxt   = fld + 2'd1;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            NEWLINE: if (fire) state_nxt = eof_pend ? EOT : IDLE;
            EOT:     if (fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule
